// File: rtl/booth_mul_sequencer_if.sv
// Control bundle between the Booth multiplier sequencer and its datapath/requester.
// The sequencer is the slave; the requester drives start/abort and the datapath Q bits.
interface booth_mul_sequencer_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic             abort;
  logic             q0;
  logic             q_m1;
  logic             clr;
  logic             load;
  logic             rwe_M;
  logic             rwe_A;
  logic             rwe_Q;
  logic             rwe_Qlessbit;
  logic             add_sub;
  logic             shift;
  logic             out_res_A_e;
  logic             out_res_Q_e;
  logic [CNT_W-1:0] iter_cnt;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, q0, q_m1,
    input  clr, load, rwe_M, rwe_A, rwe_Q, rwe_Qlessbit, add_sub, shift,
           out_res_A_e, out_res_Q_e, iter_cnt, busy, done
  );

  modport slave (
    input  start, abort, q0, q_m1,
    output clr, load, rwe_M, rwe_A, rwe_Q, rwe_Qlessbit, add_sub, shift,
           out_res_A_e, out_res_Q_e, iter_cnt, busy, done
  );
endinterface

// File: rtl/booth_mul_sequencer.sv
// Control FSM for the radix-2 Booth shift-add multiplier: LOAD, then WIDTH
// ARITH/SHIFT pairs, then a one-cycle OUT with done; owns the iteration counter.
module booth_mul_sequencer #(
  parameter int WIDTH = 25,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  booth_mul_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ARITH = 3'd2,
    SHIFT = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_dec;

  assign cnt_dec = cnt_q - CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // SHIFT with one iteration left exits to OUT, so the counter never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = LOAD;
      end
      LOAD: begin
        state_d = ARITH;
        cnt_d   = CNT_W'(WIDTH);
      end
      ARITH: state_d = SHIFT;
      SHIFT: begin
        cnt_d   = cnt_dec;
        state_d = (cnt_dec != '0) ? ARITH : OUT;
      end
      OUT: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Moore decode, except the ARITH add/sub choice which follows the Booth pair {q0,q_m1}.
  always_comb begin
    bus.clr          = 1'b0;
    bus.load         = 1'b0;
    bus.rwe_M        = 1'b0;
    bus.rwe_A        = 1'b0;
    bus.rwe_Q        = 1'b0;
    bus.rwe_Qlessbit = 1'b0;
    bus.add_sub      = 1'b0;
    bus.shift        = 1'b0;
    bus.out_res_A_e  = 1'b0;
    bus.out_res_Q_e  = 1'b0;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    case (state_q)
      LOAD: begin
        bus.clr          = 1'b1;
        bus.load         = 1'b1;
        bus.rwe_M        = 1'b1;
        bus.rwe_Q        = 1'b1;
        bus.rwe_Qlessbit = 1'b1;
        bus.busy         = 1'b1;
      end
      ARITH: begin
        bus.rwe_A   = bus.q0 ^ bus.q_m1;
        bus.add_sub = bus.q0 & ~bus.q_m1;
        bus.busy    = 1'b1;
      end
      SHIFT: begin
        bus.shift        = 1'b1;
        bus.rwe_A        = 1'b1;
        bus.rwe_Q        = 1'b1;
        bus.rwe_Qlessbit = 1'b1;
        bus.busy         = 1'b1;
      end
      OUT: begin
        bus.out_res_A_e = 1'b1;
        bus.out_res_Q_e = 1'b1;
        bus.done        = 1'b1;
        bus.busy        = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.iter_cnt = cnt_q;

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Scoreboard bench for booth_mul_sequencer: a 25-bit and a 4-bit instance checked
// every cycle against an operation-position reference model plus a done-time queue.
module tb_booth_mul_sequencer;

  localparam int WA = 25;
  localparam int CA = 5;
  localparam int WB = 4;
  localparam int CB = 3;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;

  booth_mul_sequencer_if #(.CNT_W(CA)) a_if ();
  booth_mul_sequencer_if #(.CNT_W(CB)) b_if ();

  booth_mul_sequencer #(.WIDTH(WA), .CNT_W(CA)) dut_a (.clk(clk), .reset_n(rst_a_n), .bus(a_if));
  booth_mul_sequencer #(.WIDTH(WB), .CNT_W(CB)) dut_b (.clk(clk), .reset_n(rst_b_n), .bus(b_if));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Position within an operation: 0 idle, 1 load, 2..2W+1 arith/shift pairs, 2W+2 out.
  int k_a = 0;
  int k_b = 0;

  logic [16:0] exp_a[$];
  logic [16:0] exp_b[$];
  int          done_a[$];
  int          done_b[$];

  logic b_start = 1'b0;
  logic b_abort = 1'b0;
  logic b_q0    = 1'b0;
  logic b_qm1   = 1'b0;

  logic [16:0] act_a, act_b;
  assign act_a = {a_if.clr, a_if.load, a_if.rwe_M, a_if.rwe_A, a_if.rwe_Q, a_if.rwe_Qlessbit,
                  a_if.add_sub, a_if.shift, a_if.out_res_A_e, a_if.out_res_Q_e, a_if.busy,
                  a_if.done, a_if.iter_cnt};
  assign act_b = {b_if.clr, b_if.load, b_if.rwe_M, b_if.rwe_A, b_if.rwe_Q, b_if.rwe_Qlessbit,
                  b_if.add_sub, b_if.shift, b_if.out_res_A_e, b_if.out_res_Q_e, b_if.busy,
                  b_if.done, 2'b00, b_if.iter_cnt};

  function automatic logic [16:0] model_out(int k, int w, logic q0, logic qm1);
    logic [11:0] c;
    int          rem;
    c   = '0;
    rem = 0;
    if (k == 1) begin
      c[11] = 1'b1; c[10] = 1'b1; c[9] = 1'b1; c[7] = 1'b1; c[6] = 1'b1; c[1] = 1'b1;
    end else if (k >= 2 && k <= 2*w+1) begin
      rem  = w - (k - 2) / 2;
      c[1] = 1'b1;
      if (k % 2 == 0) begin
        c[8] = q0 ^ qm1;
        c[5] = q0 & ~qm1;
      end else begin
        c[4] = 1'b1; c[8] = 1'b1; c[7] = 1'b1; c[6] = 1'b1;
      end
    end else if (k == 2*w+2) begin
      c[3] = 1'b1; c[2] = 1'b1; c[1] = 1'b1; c[0] = 1'b1;
    end
    return {c, 5'(rem)};
  endfunction

  function automatic int next_k(int k, int w, logic rn, logic st, logic ab,
                                output bit acc, output bit canc);
    acc  = 1'b0;
    canc = 1'b0;
    if (!rn) begin
      canc = (k > 0 && k < 2*w+2);
      return 0;
    end
    if (k == 0) begin
      acc = st;
      return st ? 1 : 0;
    end
    if (ab) begin
      canc = (k < 2*w+2);
      return 0;
    end
    if (k == 2*w+2) return 0;
    return k + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    bit acc, canc;
    @(posedge clk);
    cyc++;
    k_a = next_k(k_a, WA, rst_a_n, a_if.start, a_if.abort, acc, canc);
    if (acc) done_a.push_back(cyc + 2*WA + 1);
    if (canc) done_a.delete(done_a.size() - 1);
    k_b = next_k(k_b, WB, rst_b_n, b_if.start, b_if.abort, acc, canc);
    if (acc) done_b.push_back(cyc + 2*WB + 1);
    if (canc) done_b.delete(done_b.size() - 1);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic q0, input logic qm1);
    a_if.start = st;
    a_if.abort = ab;
    a_if.q0    = q0;
    a_if.q_m1  = qm1;
    exp_a.push_back(model_out(k_a, WA, q0, qm1));
    b_if.start = b_start;
    b_if.abort = b_abort;
    b_if.q0    = b_q0;
    b_if.q_m1  = b_qm1;
    exp_b.push_back(model_out(k_b, WB, b_q0, b_qm1));
  endtask

  task automatic asyncReset(input bit sel_b);
    @(negedge clk);
    #2;
    if (!sel_b) begin
      rst_a_n = 1'b0;
      if (k_a > 0 && k_a < 2*WA+2) done_a.delete(done_a.size() - 1);
      k_a = 0;
      #1;
      checkOutput("rstA_async", 32'(act_a), 32'd0);
    end else begin
      rst_b_n = 1'b0;
      if (k_b > 0 && k_b < 2*WB+2) done_b.delete(done_b.size() - 1);
      k_b = 0;
      #1;
      checkOutput("rstB_async", 32'(act_b), 32'd0);
    end
  endtask

  function automatic logic [1:0] qpat(int k);
    logic [1:0] p;
    p = 2'b00;
    if (k % 2 == 0) begin
      case (k / 2)
        1: p = 2'b10;
        2: p = 2'b01;
        3: p = 2'b11;
        default: p = 2'b00;
      endcase
    end
    return p;
  endfunction

  // Monitor: pops one expected control vector per cycle and checks every done pulse's time.
  always @(negedge clk) begin
    if (exp_a.size() > 0) checkOutput("ctrlA", 32'(act_a), 32'(exp_a.pop_front()));
    if (exp_b.size() > 0) checkOutput("ctrlB", 32'(act_b), 32'(exp_b.pop_front()));
    if (a_if.done) begin
      if (done_a.size() > 0) checkOutput("doneA_time", cyc, done_a.pop_front());
      else checkOutput("doneA_unexpected", cyc, 32'hFFFF_FFFF);
    end
    if (b_if.done) begin
      if (done_b.size() > 0) checkOutput("doneB_time", cyc, done_b.pop_front());
      else checkOutput("doneB_unexpected", cyc, 32'hFFFF_FFFF);
    end
  end

  initial begin
    logic [1:0] qp;
    a_if.start = 1'b0; a_if.abort = 1'b0; a_if.q0 = 1'b0; a_if.q_m1 = 1'b0;
    b_if.start = 1'b0; b_if.abort = 1'b0; b_if.q0 = 1'b0; b_if.q_m1 = 1'b0;

    for (int i = 0; i < 3; i++) begin tick(); applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); end
    tick(); rst_a_n = 1'b1; rst_b_n = 1'b1; applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin tick(); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0); end

    // Plain operation with quiet Booth bits and a stray start mid-run.
    tick(); applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 58; i++) begin tick(); applyStimulus(k_a == 30, 1'b0, 1'b0, 1'b0); end

    // Booth pairs 10, 01, 11 in the first three ARITH cycles.
    tick(); applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 56; i++) begin
      tick(); qp = qpat(k_a); applyStimulus(1'b0, 1'b0, qp[1], qp[0]);
    end

    // Abort in ARITH of iteration 10, then a full run.
    tick(); applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      tick(); applyStimulus(1'b0, k_a == 20, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    tick(); applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 56; i++) begin tick(); applyStimulus(1'b0, 1'b0, 1'b1, 1'b0); end

    // Abort during OUT, then abort together with start while idle.
    tick(); applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 56; i++) begin tick(); applyStimulus(1'b0, k_a == 2*WA+2, 1'b0, 1'b1); end
    tick(); applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 56; i++) begin tick(); applyStimulus(1'b0, 1'b0, 1'b1, 1'b1); end

    // Start held high: back-to-back operations.
    for (int i = 0; i < 120; i++) begin
      tick(); applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 60; i++) begin tick(); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0); end

    // Reset in the middle of an operation.
    tick(); applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 60 && k_a != 15; i++) begin tick(); applyStimulus(1'b0, 1'b0, 1'b1, 1'b0); end
    checkOutput("reach_k15", 32'(k_a), 32'd15);
    asyncReset(1'b0);
    tick(); rst_a_n = 1'b1; applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin tick(); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0); end

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      tick();
      applyStimulus(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 149) == 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 60; i++) begin tick(); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0); end

    // Narrow instance: full run, then reset in SHIFT of iteration 2.
    b_start = 1'b1;
    tick(); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    b_start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick(); b_q0 = 1'($urandom_range(0, 1)); b_qm1 = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
    b_start = 1'b1;
    tick(); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    b_start = 1'b0;
    for (int i = 0; i < 20 && k_b != 5; i++) begin tick(); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0); end
    checkOutput("reach_b_shift2", 32'(k_b), 32'd5);
    asyncReset(1'b1);
    tick(); rst_b_n = 1'b1; applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin tick(); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0); end

    @(negedge clk);
    #1;
    checkOutput("pendA", 32'(done_a.size()), 32'd0);
    checkOutput("pendB", 32'(done_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
